// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache request/response port among NUM_REQ requesters.
// Responses return in order and are routed back through an in-order ID FIFO.
module cache_port_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned TRANS_ID_WIDTH  = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]          req_addr,
    input  logic [NUM_REQ*2-1:0]                   req_type,
    input  logic [NUM_REQ*TRANS_ID_WIDTH-1:0]      req_trans_id,
    output logic [NUM_REQ-1:0]                     resp_valid,
    input  logic [NUM_REQ-1:0]                     resp_ready,
    output logic [DATA_WIDTH-1:0]                  resp_data,
    output logic                                   resp_hit,
    output logic [TRANS_ID_WIDTH-1:0]              resp_trans_id,
    output logic                                   cache_req_valid,
    input  logic                                   cache_req_ready,
    output logic [ADDR_WIDTH-1:0]                  cache_req_addr,
    output logic [1:0]                             cache_req_type,
    output logic [TRANS_ID_WIDTH-1:0]              cache_req_trans_id,
    input  logic                                   cache_resp_valid,
    output logic                                   cache_resp_ready,
    input  logic [DATA_WIDTH-1:0]                  cache_resp_data,
    input  logic                                   cache_resp_hit,
    input  logic [TRANS_ID_WIDTH-1:0]              cache_resp_trans_id,
    output logic [$clog2(MAX_OUTSTANDING):0]       outstanding,
    output logic                                   err_spurious,
    output logic                                   err_id_mismatch
);
    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_WIDTH-1:0]     addr_arr [NUM_REQ];
    logic [1:0]                type_arr [NUM_REQ];
    logic [TRANS_ID_WIDTH-1:0] id_arr   [NUM_REQ];

    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]             held_q, held_d;
    logic                      lock_q, lock_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [IW-1:0]             fifo_idx_q [MAX_OUTSTANDING];
    logic [IW-1:0]             fifo_idx_d [MAX_OUTSTANDING];
    logic [TRANS_ID_WIDTH-1:0] fifo_id_q  [MAX_OUTSTANDING];
    logic [TRANS_ID_WIDTH-1:0] fifo_id_d  [MAX_OUTSTANDING];
    logic                      err_spurious_q, err_spurious_d;
    logic                      err_id_mismatch_q, err_id_mismatch_d;

    logic [IW-1:0]             grant;
    logic                      has_grant;
    logic                      full, nonempty, accept, pop;
    logic [IW-1:0]             head_idx;
    logic [TRANS_ID_WIDTH-1:0] head_id;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            type_arr[i] = req_type[i*2 +: 2];
            id_arr[i]   = req_trans_id[i*TRANS_ID_WIDTH +: TRANS_ID_WIDTH];
        end
    end

    // A stalled request keeps its grant regardless of what other requesters do.
    always_comb begin
        int unsigned j;
        j         = 0;
        grant     = rr_ptr_q;
        has_grant = 1'b0;
        if (lock_q) begin
            grant     = held_q;
            has_grant = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                j = (32'(rr_ptr_q) + k) % NUM_REQ;
                if (!has_grant && req_valid[IW'(j)]) begin
                    grant     = IW'(j);
                    has_grant = 1'b1;
                end
            end
        end
    end

    assign full     = (count_q == CW'(MAX_OUTSTANDING));
    assign nonempty = (count_q != '0);
    assign head_idx = fifo_idx_q[rd_ptr_q];
    assign head_id  = fifo_id_q[rd_ptr_q];

    assign cache_req_valid    = has_grant & ~full & ~rst;
    assign accept             = cache_req_valid & cache_req_ready;
    assign req_ready          = accept ? (NUM_REQ'(1) << grant) : '0;
    assign cache_req_addr     = (rst || !has_grant) ? '0 : addr_arr[grant];
    assign cache_req_type     = (rst || !has_grant) ? '0 : type_arr[grant];
    assign cache_req_trans_id = (rst || !has_grant) ? '0 : id_arr[grant];

    assign cache_resp_ready = nonempty & resp_ready[head_idx];
    assign resp_valid       = (cache_resp_valid && nonempty) ? (NUM_REQ'(1) << head_idx) : '0;
    assign pop              = cache_resp_valid & cache_resp_ready;
    assign resp_data        = rst ? '0 : cache_resp_data;
    assign resp_hit         = rst ? 1'b0 : cache_resp_hit;
    assign resp_trans_id    = rst ? '0 : cache_resp_trans_id;

    assign outstanding     = count_q;
    assign err_spurious    = err_spurious_q;
    assign err_id_mismatch = err_id_mismatch_q;

    always_comb begin
        rr_ptr_d          = rr_ptr_q;
        held_d            = held_q;
        lock_d            = lock_q;
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        fifo_idx_d        = fifo_idx_q;
        fifo_id_d         = fifo_id_q;
        err_spurious_d    = err_spurious_q;
        err_id_mismatch_d = err_id_mismatch_q;
        count_d           = count_q;

        if (accept) begin
            fifo_idx_d[wr_ptr_q] = grant;
            fifo_id_d[wr_ptr_q]  = id_arr[grant];
            wr_ptr_d             = wr_ptr_q + 1'b1;
            rr_ptr_d             = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            lock_d               = 1'b0;
        end else if (cache_req_valid) begin
            lock_d = 1'b1;
            held_d = grant;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (cache_resp_trans_id != head_id)
                err_id_mismatch_d = 1'b1;
        end

        if (cache_resp_valid && !nonempty)
            err_spurious_d = 1'b1;

        if (accept && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !accept)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q          <= '0;
            held_q            <= '0;
            lock_q            <= 1'b0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            err_spurious_q    <= 1'b0;
            err_id_mismatch_q <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_idx_q[i] <= '0;
                fifo_id_q[i]  <= '0;
            end
        end else begin
            rr_ptr_q          <= rr_ptr_d;
            held_q            <= held_d;
            lock_q            <= lock_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            err_spurious_q    <= err_spurious_d;
            err_id_mismatch_q <= err_id_mismatch_d;
            fifo_idx_q        <= fifo_idx_d;
            fifo_id_q         <= fifo_id_d;
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_cache_port_arbiter;
    localparam int NUM_REQ = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TW      = 8;
    localparam int MAXO    = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*2-1:0]  req_type;
    logic [NUM_REQ*TW-1:0] req_trans_id;
    logic [DW-1:0]         resp_data, cache_resp_data;
    logic                  resp_hit, cache_resp_hit;
    logic [TW-1:0]         resp_trans_id, cache_req_trans_id, cache_resp_trans_id;
    logic                  cache_req_valid, cache_req_ready, cache_resp_valid, cache_resp_ready;
    logic [AW-1:0]         cache_req_addr;
    logic [1:0]            cache_req_type;
    logic [2:0]            outstanding;
    logic                  err_spurious, err_id_mismatch;

    logic [AW-1:0] a_addr [NUM_REQ];
    logic [1:0]    a_type [NUM_REQ];
    logic [TW-1:0] a_tid  [NUM_REQ];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*AW +: AW]     = a_addr[i];
            req_type[i*2 +: 2]       = a_type[i];
            req_trans_id[i*TW +: TW] = a_tid[i];
        end
    end

    cache_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .TRANS_ID_WIDTH(TW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_type(req_type), .req_trans_id(req_trans_id),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_hit(resp_hit), .resp_trans_id(resp_trans_id),
        .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
        .cache_req_addr(cache_req_addr), .cache_req_type(cache_req_type),
        .cache_req_trans_id(cache_req_trans_id),
        .cache_resp_valid(cache_resp_valid), .cache_resp_ready(cache_resp_ready),
        .cache_resp_data(cache_resp_data), .cache_resp_hit(cache_resp_hit),
        .cache_resp_trans_id(cache_resp_trans_id),
        .outstanding(outstanding), .err_spurious(err_spurious),
        .err_id_mismatch(err_id_mismatch)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding requests as a plain queue of {issuer, id}.
    typedef struct {
        int      idx;
        logic [TW-1:0] id;
    } ent_t;

    ent_t m_q[$];
    int   m_rr     = 0;
    bit   m_locked = 0;
    int   m_held   = 0;
    bit   m_spur   = 0;
    bit   m_mism   = 0;

    int   g;
    bit   has, crv, acc, ne, crr, pop;
    ent_t h;
    logic [NUM_REQ-1:0] erv;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_cache_req_valid", cache_req_valid, 0);
            chk("rst_cache_req_addr", cache_req_addr, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_cache_resp_ready", cache_resp_ready, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_outstanding", outstanding, 0);
            chk("rst_err_spurious", err_spurious, 0);
            chk("rst_err_id_mismatch", err_id_mismatch, 0);
            m_q.delete();
            m_rr = 0; m_locked = 0; m_held = 0; m_spur = 0; m_mism = 0;
        end else begin
            has = 0; g = 0;
            if (m_locked) begin
                g = m_held; has = 1;
            end else begin
                for (int k = 0; k < NUM_REQ; k++)
                    if (!has && req_valid[(m_rr + k) % NUM_REQ]) begin
                        g = (m_rr + k) % NUM_REQ; has = 1;
                    end
            end
            crv = has && (m_q.size() < MAXO);
            acc = crv && cache_req_ready;
            ne  = m_q.size() > 0;
            h.idx = 0; h.id = '0;
            if (ne) h = m_q[0];
            crr = ne && resp_ready[h.idx];
            erv = (cache_resp_valid && ne) ? NUM_REQ'(1 << h.idx) : '0;
            pop = cache_resp_valid && crr;

            chk("m_cache_req_valid", cache_req_valid, crv);
            chk("m_req_ready", req_ready, acc ? (1 << g) : 0);
            if (crv) begin
                chk("m_cache_req_addr", cache_req_addr, a_addr[g]);
                chk("m_cache_req_type", cache_req_type, a_type[g]);
                chk("m_cache_req_trans_id", cache_req_trans_id, a_tid[g]);
            end
            chk("m_resp_valid", resp_valid, erv);
            chk("m_cache_resp_ready", cache_resp_ready, crr);
            chk("m_resp_data", resp_data, cache_resp_data);
            chk("m_resp_hit", resp_hit, cache_resp_hit);
            chk("m_resp_trans_id", resp_trans_id, cache_resp_trans_id);
            chk("m_outstanding", outstanding, m_q.size());
            chk("m_err_spurious", err_spurious, m_spur);
            chk("m_err_id_mismatch", err_id_mismatch, m_mism);

            if (pop) begin
                if (cache_resp_trans_id != h.id) m_mism = 1;
                void'(m_q.pop_front());
            end
            if (cache_resp_valid && !ne) m_spur = 1;
            if (acc) begin
                m_q.push_back('{idx: g, id: a_tid[g]});
                m_rr = (g + 1) % NUM_REQ;
                m_locked = 0;
            end else if (crv) begin
                m_locked = 1;
                m_held = g;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0; resp_ready = '1; cache_req_ready = 1'b0;
        cache_resp_valid = 1'b0; cache_resp_data = '0; cache_resp_hit = 1'b0;
        cache_resp_trans_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_addr[i] = 32'h1000 + i;
            a_type[i] = 2'(i);
            a_tid[i]  = 8'h40 + 8'(i);
        end
        tick(); tick();
        rst = 1'b0;

        // 1: everyone requesting, prompt in-order responses
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 5) ? 4'hF : 4'h0;
            cache_req_ready = 1'b1;
            cache_resp_valid = (c >= 1);
            cache_resp_trans_id = 8'h40 + 8'((c + 3) % 4);
            cache_resp_data = 32'hD000 + c;
            cache_resp_hit = c[0];
            mid();
            if (c < 5) chk("t1_grant", req_ready, 1 << (c % 4));
            if (c >= 1) chk("t1_route", resp_valid, 1 << ((c + 3) % 4));
            tick();
        end
        cache_resp_valid = 1'b0;
        mid(); chk("t1_drained", outstanding, 0); tick();

        // 2: stalled grant to 2 held while 1 raises valid
        for (int s = 0; s < 4; s++) begin
            req_valid = (s == 0) ? 4'b0100 : 4'b0110;
            cache_req_ready = (s == 3);
            mid();
            chk("t2_hold_valid", cache_req_valid, 1);
            chk("t2_hold_addr", cache_req_addr, 32'h1002);
            chk("t2_hold_id", cache_req_trans_id, 8'h42);
            chk("t2_ready", req_ready, (s == 3) ? 4'b0100 : 4'b0000);
            tick();
        end
        req_valid = 4'b0010;
        mid(); chk("t2_next_grant", req_ready, 4'b0010); tick();
        req_valid = '0;
        cache_resp_valid = 1'b1; cache_resp_trans_id = 8'h42;
        mid(); chk("t2_route2", resp_valid, 4'b0100); tick();
        cache_resp_trans_id = 8'h41;
        mid(); chk("t2_route1", resp_valid, 4'b0010); tick();
        cache_resp_valid = 1'b0;

        // 3: fill the FIFO, then free one slot
        for (int s = 0; s < 4; s++) begin
            req_valid = 4'hF;
            mid(); chk("t3_fill", req_ready, 1 << ((2 + s) % 4)); tick();
        end
        mid();
        chk("t3_full_outstanding", outstanding, 4);
        chk("t3_full_ready", req_ready, 0);
        chk("t3_full_valid", cache_req_valid, 0);
        tick();
        cache_resp_valid = 1'b1; cache_resp_trans_id = 8'h42;
        mid();
        chk("t3_pop_ready", cache_resp_ready, 1);
        chk("t3_no_passthru", req_ready, 0);
        tick();
        cache_resp_valid = 1'b0;
        mid();
        chk("t3_after_pop", outstanding, 3);
        chk("t3_fifth_accept", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        mid(); chk("t3_refull", outstanding, 4); tick();
        for (int s = 0; s < 4; s++) begin
            cache_resp_valid = 1'b1;
            cache_resp_trans_id = 8'h40 + 8'((3 + s) % 4);
            mid(); chk("t3_drain_route", resp_valid, 1 << ((3 + s) % 4)); tick();
        end
        cache_resp_valid = 1'b0;

        // 4: response backpressure from requester 3
        a_tid[3] = 8'h10; a_tid[1] = 8'h22;
        req_valid = 4'b1000;
        mid(); chk("t4_grant3", req_ready, 4'b1000); tick();
        req_valid = 4'b0010;
        mid(); chk("t4_grant1", req_ready, 4'b0010); tick();
        req_valid = '0;
        cache_resp_valid = 1'b1; cache_resp_trans_id = 8'h10; resp_ready = 4'b0111;
        for (int s = 0; s < 2; s++) begin
            mid();
            chk("t4_bp_ready", cache_resp_ready, 0);
            chk("t4_bp_valid", resp_valid, 4'b1000);
            tick();
        end
        resp_ready = '1;
        mid(); chk("t4_deliver3", cache_resp_ready, 1); chk("t4_route3", resp_valid, 4'b1000); tick();
        cache_resp_trans_id = 8'h22;
        mid(); chk("t4_route1", resp_valid, 4'b0010); tick();
        cache_resp_valid = 1'b0;

        // 5: spurious response and ID mismatch
        cache_resp_valid = 1'b1; cache_resp_trans_id = 8'h99;
        mid();
        chk("t5_spur_ready", cache_resp_ready, 0);
        chk("t5_spur_valid", resp_valid, 0);
        tick();
        cache_resp_valid = 1'b0;
        mid(); chk("t5_spur_flag", err_spurious, 1); tick();
        mid(); chk("t5_spur_sticky", err_spurious, 1); tick();
        a_tid[0] = 8'h10;
        req_valid = 4'b0001;
        mid(); chk("t5_grant0", req_ready, 4'b0001); tick();
        req_valid = '0;
        cache_resp_valid = 1'b1; cache_resp_trans_id = 8'h11;
        mid();
        chk("t5_mism_route", resp_valid, 4'b0001);
        chk("t5_mism_ready", cache_resp_ready, 1);
        tick();
        cache_resp_valid = 1'b0;
        mid(); chk("t5_mism_flag", err_id_mismatch, 1); chk("t5_mism_pop", outstanding, 0); tick();

        // 6: reset with requests outstanding
        for (int i = 0; i < NUM_REQ; i++) a_tid[i] = 8'h40 + 8'(i);
        req_valid = 4'b0111;
        mid(); chk("t6_grant1", req_ready, 4'b0010); tick();
        mid(); chk("t6_grant2", req_ready, 4'b0100); tick();
        mid(); chk("t6_grant0", req_ready, 4'b0001); tick();
        req_valid = 4'hF; cache_req_ready = 1'b0;
        mid(); chk("t6_pre_outstanding", outstanding, 3); tick();
        rst = 1'b1;
        mid(); chk("t6_rst_outstanding", outstanding, 0); chk("t6_rst_flags", {err_spurious, err_id_mismatch}, 0); tick();
        rst = 1'b0; cache_req_ready = 1'b1; req_valid = 4'b0110;
        mid(); chk("t6_post_grant", req_ready, 4'b0010); tick();
        req_valid = '0;
        cache_resp_valid = 1'b1; cache_resp_trans_id = 8'h41;
        mid(); chk("t6_post_route", resp_valid, 4'b0010); tick();
        cache_resp_valid = 1'b0;
        mid(); chk("t6_post_flags", {err_spurious, err_id_mismatch}, 0); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
